pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Parametrised supervisor for the iCE40 PLL. It drives the PLL's active-low reset, synchronises and qualifies the PLL `LOCK` signal, and asserts `READY` only after lock has been stable for a programmable time. On lock loss it automatically re-resets the PLL and counts the event. A lock timeout triggers a bounded number of retries, after which the block latches a fault. It sits between the board reference clock/reset and the PLL primitive, and its `READY` gates the sample-clock reset of the downstream capture logic.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16 — cycles `PLL_RESETB` is held low per reset attempt (≥1).
- `LOCK_STABLE_CYCLES`, 256 — consecutive synchronised-lock-high cycles required before `READY` (≥1).
- `LOCK_TIMEOUT`, 65536 — maximum cycles from `PLL_RESETB` release to qualified lock (> `LOCK_STABLE_CYCLES`).
- `MAX_RETRIES`, 3 — timeout retries allowed before `FAULT` (0 = no retry).
- `SYNC_STAGES`, 2 — `LOCK` synchroniser depth (≥2).

Ports:
- `REFERENCECLK` in 1 — single clock (board reference clock); all logic is on its rising edge.
- `RESET` in 1 — synchronous, active-low reset.
- `LOCK` in 1 — PLL lock, asynchronous to `REFERENCECLK`.
- `CLEAR_FAULT` in 1 — synchronous pulse; leaves FAULT state.
- `PLL_RESETB` out 1 — PLL reset, active low, registered.
- `READY` out 1 — clock qualified; high only in RUN.
- `FAULT` out 1 — high only in FAULT.
- `RELOCK_CNT` out 8 — saturating count of lock losses while in RUN.
- `STATE` out 3 — debug: 0=RST, 1=WAIT, 2=STABLE, 3=RUN, 4=FAULT.

## Operation
- `lock_s` is `LOCK` after `SYNC_STAGES` flops. The synchroniser flops reset to 0.
- Outputs are Moore-decoded from the registered state:
  - `PLL_RESETB` = (state≠RST && state≠FAULT)
  - `READY` = (state==RUN)
  - `FAULT` = (state==FAULT)
- Counters:
  - `phase_cnt` is reloaded on every state entry.
  - `tmo_cnt` is cleared on WAIT entry from RST and runs through WAIT and STABLE.
  - `retry_cnt` ranges 0..`MAX_RETRIES`.
  - Counter widths are `$clog2` of the largest value each must hold, plus 1.
- **RST**: count `PLL_RST_CYCLES` cycles, then go to WAIT.
- **WAIT**:
  - `lock_s`=1 → STABLE.
  - `tmo_cnt` reaches `LOCK_TIMEOUT`-1 → timeout.
- **STABLE**:
  - `lock_s`=0 → WAIT, with `tmo_cnt` not cleared.
  - `LOCK_STABLE_CYCLES` consecutive high cycles → RUN, and `retry_cnt` ← 0.
  - A timeout also applies in STABLE.
- **Timeout** (from WAIT or STABLE):
  - `retry_cnt` < `MAX_RETRIES` → `retry_cnt`++, go to RST.
  - Otherwise → FAULT.
- **RUN**: `lock_s`=0 → RST, `RELOCK_CNT`++ saturating at 255, `retry_cnt` ← 0.
- **FAULT**: `PLL_RESETB` is held low. `CLEAR_FAULT`=1 → RST with `retry_cnt` ← 0. `RELOCK_CNT` is preserved.
- `CLEAR_FAULT` is ignored in all states except FAULT.
- Simultaneous events:
  - In STABLE, a timeout on the same cycle the stable count completes: completion wins → RUN.
  - A lock drop in STABLE on the same cycle as a timeout: timeout wins.
- `RESET`=0 in any state, including mid-operation, takes effect at the next edge and overrides everything:
  - state ← RST; all counters and `RELOCK_CNT` ← 0.
  - `PLL_RESETB` ← 0, `READY` ← 0, `FAULT` ← 0.

## Timing
- Reset values: `PLL_RESETB`=0, `READY`=0, `FAULT`=0, `RELOCK_CNT`=0, `STATE`=0.
- Reset release:
  - Call the first edge with `RESET`=1 "edge 0".
  - `PLL_RESETB` stays low through edge `PLL_RST_CYCLES`-1.
  - It rises after edge `PLL_RST_CYCLES`.
- `LOCK` rise to `lock_s` rise: `SYNC_STAGES` edges.
- `lock_s` high in WAIT to STABLE entry: 1 edge.
- STABLE entry to `READY`=1: `LOCK_STABLE_CYCLES` edges.
- Lock drop in RUN: `READY` falls and `PLL_RESETB` falls `SYNC_STAGES`+1 edges after `LOCK` falls. `RELOCK_CNT` updates on the same edge.
- FAULT exit: `CLEAR_FAULT` sampled high → state RST on the next edge. `FAULT` falls on that edge.
- `LOCK` glitches shorter than one clock may be missed. This is accepted; qualification requires sustained lock.

## Test plan
Bench parameters: `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT`=32, `MAX_RETRIES`=2, `SYNC_STAGES`=2.

- **Normal bring-up**:
  - Stimulus: release `RESET`; raise `LOCK` 6 cycles after `PLL_RESETB` rises.
  - Required: `PLL_RESETB` low for exactly 4 cycles; `READY` rises 11 cycles after the `LOCK` rise; `STATE`=3; `FAULT`=0.
- **Chatter in STABLE**:
  - Stimulus: `LOCK` high for 5 cycles, low for 3, then high.
  - Required: STATE returns to 1; the stable count restarts; `READY` rises 11 cycles after the second `LOCK` rise; `RELOCK_CNT`=0.
- **Lock loss in RUN**:
  - Stimulus: drop `LOCK` while `READY`=1.
  - Required: `READY`=0 and `PLL_RESETB`=0 3 cycles later; `RELOCK_CNT`=1; after `LOCK` returns, re-qualification completes.
  - Repeat 300 times: `RELOCK_CNT` saturates at 255.
- **Timeout and fault**:
  - Stimulus: hold `LOCK`=0 throughout.
  - Required: three `PLL_RESETB` low pulses of 4 cycles each, separated by 32 high cycles; `FAULT`=1 at cycle 108 after reset release; `PLL_RESETB` stays low.
- **Fault recovery**:
  - Stimulus: pulse `CLEAR_FAULT` while in FAULT, with `LOCK` now behaving normally.
  - Required: `FAULT`=0 next edge; a fresh 4-cycle `PLL_RESETB` pulse; `READY` follows.
  - Check: `CLEAR_FAULT` pulsed while in RUN has no effect.
- **Reset mid-operation**:
  - Stimulus: assert `RESET`=0 for 1 cycle while in STABLE, and again while in RUN with `RELOCK_CNT`=5.
  - Required: next edge all outputs return to their reset values; `RELOCK_CNT`=0; the sequence restarts from RST.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// Supervisor for the iCE40 PLL: sequences PLL reset, qualifies a synchronised LOCK,
// re-resets on lock loss, and latches a fault after bounded timeout retries.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int MAX_RETRIES        = 3,
    parameter int SYNC_STAGES        = 2
) (
    input  logic       REFERENCECLK,
    input  logic       RESET,
    input  logic       LOCK,
    input  logic       CLEAR_FAULT,
    output logic       PLL_RESETB,
    output logic       READY,
    output logic       FAULT,
    output logic [7:0] RELOCK_CNT,
    output logic [2:0] STATE
);

    localparam int PH_MAX = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES
                                                                  : LOCK_STABLE_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX) + 1;
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT) + 1;
    localparam int RTY_W  = $clog2(MAX_RETRIES) + 1;

    localparam logic [PH_W-1:0]  PH_TOP  = PH_W'(PH_MAX);
    localparam logic [PH_W-1:0]  RST_END = PH_W'(PLL_RST_CYCLES);
    localparam logic [PH_W-1:0]  STB_END = PH_W'(LOCK_STABLE_CYCLES);
    localparam logic [TMO_W-1:0] TMO_END = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t               state;
    state_t               nxt;
    state_t               tmo_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                 lock_s;
    logic [PH_W-1:0]      phase_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [RTY_W-1:0]     retry_cnt;
    logic                 tmo_hit;
    logic                 stable_done;
    logic                 in_wt;
    logic                 nx_wt;

    // LOCK comes from the PLL's own domain; only the last stage is used.
    always_ff @(posedge REFERENCECLK) begin
        if (!RESET) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], LOCK};
    end

    assign lock_s = sync[SYNC_STAGES-1];

    // phase_cnt counts cycles spent in the current state; the entry edge counts as 1.
    assign tmo_hit     = (tmo_cnt == TMO_END);
    assign stable_done = lock_s && (phase_cnt == STB_END);
    assign in_wt       = (state == S_WAIT) || (state == S_STABLE);
    assign nx_wt       = (nxt == S_WAIT) || (nxt == S_STABLE);

    always_comb begin
        nxt     = state;
        tmo_nxt = (retry_cnt < RTY_MAX) ? S_RST : S_FAULT;
        case (state)
            S_RST:    if (phase_cnt == RST_END) nxt = S_WAIT;
            S_WAIT: begin
                if (tmo_hit)     nxt = tmo_nxt;
                else if (lock_s) nxt = S_STABLE;
            end
            // Completion beats timeout; timeout beats a lock drop.
            S_STABLE: begin
                if (stable_done)  nxt = S_RUN;
                else if (tmo_hit) nxt = tmo_nxt;
                else if (!lock_s) nxt = S_WAIT;
            end
            S_RUN:    if (!lock_s) nxt = S_RST;
            S_FAULT:  if (CLEAR_FAULT) nxt = S_RST;
            default:  nxt = S_RST;
        endcase
    end

    always_ff @(posedge REFERENCECLK) begin
        if (!RESET) begin
            state      <= S_RST;
            phase_cnt  <= '0;
            tmo_cnt    <= '0;
            retry_cnt  <= '0;
            RELOCK_CNT <= '0;
            PLL_RESETB <= 1'b0;
            READY      <= 1'b0;
            FAULT      <= 1'b0;
            STATE      <= 3'd0;
        end else begin
            state <= nxt;

            if (nxt != state)           phase_cnt <= {{(PH_W-1){1'b0}}, 1'b1};
            else if (phase_cnt != PH_TOP) phase_cnt <= phase_cnt + 1'b1;

            // Runs across WAIT<->STABLE bounces; any other path restarts it.
            tmo_cnt <= (in_wt && nx_wt) ? tmo_cnt + 1'b1 : '0;

            if ((state == S_STABLE && nxt == S_RUN) ||
                (state == S_RUN    && nxt == S_RST) ||
                (state == S_FAULT  && nxt == S_RST))
                retry_cnt <= '0;
            else if (in_wt && nxt == S_RST)
                retry_cnt <= retry_cnt + 1'b1;

            if (state == S_RUN && nxt == S_RST && RELOCK_CNT != 8'hFF)
                RELOCK_CNT <= RELOCK_CNT + 8'd1;

            // Outputs are decoded from the next state so they stay flop-driven.
            PLL_RESETB <= (nxt != S_RST) && (nxt != S_FAULT);
            READY      <= (nxt == S_RUN);
            FAULT      <= (nxt == S_FAULT);
            STATE      <= nxt;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: timed expectations are queued as stimulus is driven and
// compared on the falling edge of the cycle they target.
module tb_pll_lock_supervisor;

    logic       clk = 1'b0;
    logic       RESET, LOCK, CLEAR_FAULT;
    logic       PLL_RESETB, READY, FAULT;
    logic [7:0] RELOCK_CNT;
    logic [2:0] STATE;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT(32),
        .MAX_RETRIES(2), .SYNC_STAGES(2)
    ) dut (
        .REFERENCECLK(clk), .RESET(RESET), .LOCK(LOCK), .CLEAR_FAULT(CLEAR_FAULT),
        .PLL_RESETB(PLL_RESETB), .READY(READY), .FAULT(FAULT),
        .RELOCK_CNT(RELOCK_CNT), .STATE(STATE)
    );

    localparam int S_RSTB = 0, S_RDY = 1, S_FLT = 2, S_RLK = 3, S_ST = 4;

    typedef struct {
        int    at;
        int    sig;
        int    val;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d want %0d", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] sample(input int sig);
        case (sig)
            S_RSTB:  return {31'd0, PLL_RESETB};
            S_RDY:   return {31'd0, READY};
            S_FLT:   return {31'd0, FAULT};
            S_RLK:   return {24'd0, RELOCK_CNT};
            default: return {29'd0, STATE};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at < cyc) begin
                chk({sb[i].tag, "_late"}, cyc, sb[i].at);
                sb.delete(i);
            end else if (sb[i].at == cyc) begin
                chk(sb[i].tag, sample(sb[i].sig), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic want(input int at, input int sig, input int val, input string tag);
        exp_t e;
        e.at  = at;
        e.sig = sig;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    // Holds RESET low for n edges, queues reset-value checks, releases; b = release cycle.
    task automatic do_reset(input int n, output int b);
        RESET = 1'b0;
        tick(n);
        want(cyc, S_RSTB, 0, "rst_resetb");
        want(cyc, S_RDY,  0, "rst_ready");
        want(cyc, S_FLT,  0, "rst_fault");
        want(cyc, S_RLK,  0, "rst_relock");
        want(cyc, S_ST,   0, "rst_state");
        RESET = 1'b1;
        b = cyc;
    endtask

    // Restart after reset with LOCK already high: 4-cycle PLL reset, 1 to STABLE, 8 to RUN.
    task automatic restart_chk(input int b);
        for (int k = 1; k <= 4; k++) want(b + k, S_RSTB, 0, "restart_resetb_low");
        want(b + 5,  S_RSTB, 1, "restart_resetb_rise");
        want(b + 6,  S_ST,   2, "restart_stable");
        want(b + 13, S_RDY,  0, "restart_ready_early");
        want(b + 14, S_RDY,  1, "restart_ready");
        run_to(b + 15);
    endtask

    // Lock loss in RUN followed by re-qualification.
    task automatic relock(input int exp_cnt);
        int d;
        d = cyc;
        LOCK = 1'b0;
        want(d + 2, S_RDY,  1, "drop_ready_hold");
        want(d + 3, S_RDY,  0, "drop_ready");
        want(d + 3, S_RSTB, 0, "drop_resetb");
        want(d + 3, S_ST,   0, "drop_state");
        want(d + 3, S_RLK,  exp_cnt, "relock_cnt");
        want(d + 6, S_RSTB, 0, "relock_resetb_low");
        want(d + 7, S_RSTB, 1, "relock_resetb_rise");
        run_to(d + 7);
        LOCK = 1'b1;
        want(d + 17, S_RDY, 0, "requal_ready_early");
        want(d + 18, S_RDY, 1, "requal_ready");
        run_to(d + 18);
    endtask

    function automatic int rb_exp(input int k);
        return ((k >= 4 && k < 36) || (k >= 40 && k < 72) || (k >= 76 && k < 108)) ? 1 : 0;
    endfunction

    initial begin
        int b, x, c, d, e, p;
        RESET = 1'b0;
        LOCK = 1'b0;
        CLEAR_FAULT = 1'b0;

        // normal bring-up
        do_reset(3, b);
        for (int k = 1; k <= 4; k++) want(b + k, S_RSTB, 0, "bringup_resetb_low");
        want(b + 5, S_RSTB, 1, "bringup_resetb_rise");
        want(b + 5, S_ST,   1, "bringup_wait");
        x = b + 11;
        run_to(x);
        LOCK = 1'b1;
        want(x + 2,  S_ST,  1, "bringup_still_wait");
        want(x + 3,  S_ST,  2, "bringup_stable");
        want(x + 10, S_RDY, 0, "bringup_ready_early");
        want(x + 11, S_RDY, 1, "bringup_ready");
        want(x + 11, S_ST,  3, "bringup_run");
        want(x + 11, S_FLT, 0, "bringup_fault");
        run_to(x + 12);

        for (int i = 1; i <= 5; i++) relock(i);

        // reset while in RUN with RELOCK_CNT=5
        want(cyc, S_RLK, 5, "pre_reset_relock");
        want(cyc, S_ST,  3, "pre_reset_run");
        do_reset(1, b);
        restart_chk(b);

        // chatter in STABLE
        LOCK = 1'b0;
        do_reset(2, b);
        x = b + 7;
        run_to(x);
        LOCK = 1'b1;
        want(x + 7,  S_ST,  2, "chat_stable");
        want(x + 8,  S_ST,  1, "chat_back_wait");
        want(x + 10, S_ST,  1, "chat_wait_hold");
        want(x + 11, S_ST,  2, "chat_restable");
        want(x + 18, S_RDY, 0, "chat_ready_early");
        want(x + 18, S_ST,  2, "chat_count_restart");
        want(x + 19, S_RDY, 1, "chat_ready");
        want(x + 19, S_ST,  3, "chat_run");
        want(x + 19, S_RLK, 0, "chat_relock");
        run_to(x + 5);
        LOCK = 1'b0;
        run_to(x + 8);
        LOCK = 1'b1;
        run_to(x + 20);

        // repeated lock loss saturates the counter
        for (int i = 1; i <= 300; i++) relock((i > 255) ? 255 : i);

        // permanent lock loss: retries then fault, relock count preserved
        d = cyc;
        LOCK = 1'b0;
        e = d + 3;
        for (int k = 0; k <= 112; k++) begin
            want(e + k, S_RSTB, rb_exp(k), "tmo_resetb");
            want(e + k, S_FLT, (k >= 108) ? 1 : 0, "tmo_fault");
        end
        want(e + 107, S_ST,  1, "tmo_last_wait");
        want(e + 108, S_ST,  4, "tmo_fault_state");
        want(e + 110, S_RLK, 255, "fault_relock_kept");
        run_to(e + 112);

        // fault recovery
        c = cyc;
        CLEAR_FAULT = 1'b1;
        want(c,     S_FLT, 1, "clr_fault_before");
        want(c + 1, S_FLT, 0, "clr_fault_after");
        want(c + 1, S_ST,  0, "clr_state_rst");
        for (int k = 1; k <= 4; k++) want(c + k, S_RSTB, 0, "clr_resetb_low");
        want(c + 5, S_RSTB, 1, "clr_resetb_rise");
        tick();
        CLEAR_FAULT = 1'b0;
        run_to(c + 5);
        LOCK = 1'b1;
        want(c + 15, S_RDY, 0,   "clr_ready_early");
        want(c + 16, S_RDY, 1,   "clr_ready");
        want(c + 16, S_RLK, 255, "clr_relock_kept");
        run_to(c + 17);

        // CLEAR_FAULT in RUN is ignored
        p = cyc;
        CLEAR_FAULT = 1'b1;
        want(p + 1, S_ST,   3, "clr_run_state");
        want(p + 1, S_RDY,  1, "clr_run_ready");
        want(p + 2, S_ST,   3, "clr_run_state2");
        want(p + 2, S_RSTB, 1, "clr_run_resetb");
        tick();
        CLEAR_FAULT = 1'b0;
        run_to(p + 3);

        // reset while in STABLE
        d = cyc;
        LOCK = 1'b0;
        want(d + 3, S_ST, 0, "stb_drop_state");
        run_to(d + 7);
        LOCK = 1'b1;
        want(d + 12, S_ST, 2, "stb_pre_reset");
        run_to(d + 12);
        do_reset(1, b);
        restart_chk(b);

        tick(2);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
